fwft_fifo_flags: RTL and testbench

Parametrised first-word-fall-through (FWFT) synchronous FIFO. It is the next generation of the team's LED-board FIFO and adds configurable width and depth, a fill-level count, programmable almost-full and almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush. It sits between the host-side byte/word producer and the LED-board shift/drive logic. The head word is always presented on `data_out` without a read request; `read_en` pops it.

---
 rtl/fwft_fifo_flags.sv | 114 +++++++++++
 tb/tb_fwft_fifo_flags.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fwft_fifo_flags.sv
// First-word-fall-through synchronous FIFO with fill count, programmable
// almost-full / almost-empty thresholds, sticky overflow / underflow error
// flags and a synchronous flush. The head word is always visible on
// data_out; read_en pops it.
module fwft_fifo_flags #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 64,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     write_en,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     read_en,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             overflow_r;
  logic             underflow_r;

  logic             full_s;
  logic             empty_s;
  logic             wr_ok_s;
  logic             rd_ok_s;
  logic             ovf_set_s;
  logic             unf_set_s;

  // Flag decode from the registered count and transfer acceptance.
  always_comb begin
    full_s    = (count_r == DEPTH_C);
    empty_s   = (count_r == {CW{1'b0}});
    // A write into a full FIFO is still accepted when a pop frees a slot.
    wr_ok_s   = write_en && (!full_s || read_en);
    rd_ok_s   = read_en && !empty_s;
    ovf_set_s = write_en && full_s && !read_en;
    unf_set_s = read_en && empty_s;
  end

  // Storage write; contents survive reset and flush.
  always_ff @(posedge clk) begin
    if (wr_ok_s && !flush) begin
      mem_r[wr_ptr_r] <= data_in;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Pointers, fill count and sticky error flags; flush overrides any transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= {CW{1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (flush) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= {CW{1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({wr_ok_s, rd_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end
      if (unf_set_s) begin
        underflow_r <= 1'b1;
      end
    end
  end

  assign data_out     = mem_r[rd_ptr_r];
  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = (count_r >= AF_C);
  assign almost_empty = (count_r <= AE_C);
  assign count        = count_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

endmodule

// File: tb/tb_fwft_fifo_flags.sv
// Self-checking bench for fwft_fifo_flags: a constant vector table for the
// basic write/read sequence, plus a queue scoreboard checked every cycle
// through fill, overflow, full-throughput, underflow, flush, async reset and
// threshold sequences.
module tb_fwft_fifo_flags;

  localparam int WIDTH = 8;
  localparam int DEPTH = 64;
  localparam int AF_LV = DEPTH - 4;
  localparam int AE_LV = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush = 1'b0;
  logic             write_en = 1'b0;
  logic [WIDTH-1:0] data_in = 8'h00;
  logic             read_en = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [6:0]       count;
  logic             overflow;
  logic             underflow;

  int n_vec = 0;
  int n_bad = 0;

  logic [WIDTH-1:0] model_q[$];
  bit               m_ovf = 1'b0;
  bit               m_unf = 1'b0;

  typedef struct {
    logic       we;
    logic [7:0] din;
    logic       re;
    logic [6:0] exp_count;
    logic       exp_empty;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t tbl[6];

  fwft_fifo_flags #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LV), .AE_LEVEL(AE_LV)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .write_en(write_en),
    .data_in(data_in), .read_en(read_en), .data_out(data_out),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state();
    int sz;
    sz = model_q.size();
    chk("count", 32'(count), 32'(sz));
    chk("empty", 32'(empty), 32'(sz == 0));
    chk("full", 32'(full), 32'(sz == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(sz >= AF_LV));
    chk("almost_empty", 32'(almost_empty), 32'(sz <= AE_LV));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
    if (sz > 0) chk("head", 32'(data_out), 32'(model_q[0]));
  endtask

  // One clock cycle of stimulus; the scoreboard pops and compares the head
  // word being consumed, then the post-edge state is compared.
  task automatic step(input logic we, input logic [7:0] din, input logic re, input logic fl);
    int sz;
    logic [7:0] exp_w;
    sz = model_q.size();
    write_en = we;
    data_in  = din;
    read_en  = re;
    flush    = fl;
    if (fl) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (re && sz > 0) begin
        exp_w = model_q.pop_front();
        chk("pop_data", 32'(data_out), 32'(exp_w));
      end
      if (re && sz == 0) m_unf = 1'b1;
      if (we && sz == DEPTH && !re) m_ovf = 1'b1;
      if (we && (sz < DEPTH || re)) model_q.push_back(din);
    end
    @(posedge clk);
    #1;
    write_en = 1'b0;
    read_en  = 1'b0;
    flush    = 1'b0;
    check_state();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_ae"}, 32'(almost_empty), 32'd1);
    chk({tag, "_af"}, 32'(almost_full), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_unf"}, 32'(underflow), 32'd0);
  endtask

  initial begin
    tbl[0] = '{1'b1, 8'h01, 1'b0, 7'd1, 1'b0, 8'h01};
    tbl[1] = '{1'b1, 8'h02, 1'b0, 7'd2, 1'b0, 8'h01};
    tbl[2] = '{1'b1, 8'h03, 1'b0, 7'd3, 1'b0, 8'h01};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 7'd2, 1'b0, 8'h02};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 7'd1, 1'b0, 8'h03};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 7'd0, 1'b1, 8'h00};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b1;

    // Basic write / read table
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].we, tbl[i].din, tbl[i].re, 1'b0);
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].exp_count));
      chk($sformatf("tbl%0d_empty", i), 32'(empty), 32'(tbl[i].exp_empty));
      if (!tbl[i].exp_empty) chk($sformatf("tbl%0d_dout", i), 32'(data_out), 32'(tbl[i].exp_dout));
      chk($sformatf("tbl%0d_unf", i), 32'(underflow), 32'd0);
    end

    // Fill to full, then one rejected write
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == AF_LV - 2) chk("af_before", 32'(almost_full), 32'd0);
      if (i == AF_LV - 1) chk("af_at_60", 32'(almost_full), 32'd1);
    end
    chk("full_at_64", 32'(full), 32'd1);
    step(1'b1, 8'h40, 1'b0, 1'b0);
    chk("ovf_65th", 32'(overflow), 32'd1);
    chk("count_65th", 32'(count), 32'd64);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain_empty", 32'(empty), 32'd1);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Full with simultaneous read and write, then drain across the wrap
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
      chk("rw_full_count", 32'(count), 32'd64);
    end
    chk("rw_full_ovf", 32'(overflow), 32'd0);
    chk("rw_full_head", 32'(data_out), 32'h0A);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("wrap_empty", 32'(empty), 32'd1);

    // Underflow on empty, then read+write on empty
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("unf_set", 32'(underflow), 32'd1);
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    chk("unf_stays", 32'(underflow), 32'd1);
    chk("aa_count", 32'(count), 32'd1);
    chk("aa_dout", 32'(data_out), 32'hAA);

    // Flush with a same-cycle write
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'hBB, 1'b0, 1'b1);
    check_reset_vals("flush");
    step(1'b1, 8'h21, 1'b0, 1'b0);
    chk("post_flush_head", 32'(data_out), 32'h21);

    // Asynchronous reset off the clock edge, mid-stream, with flags set
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h31, 1'b0, 1'b0);
    write_en = 1'b1;
    data_in  = 8'h32;
    #2;
    rst = 1'b0;
    #1;
    check_reset_vals("async_rst");
    write_en = 1'b0;
    model_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(posedge clk);
    #1;
    check_reset_vals("rst_held");
    rst = 1'b1;

    // Almost-empty threshold
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    chk("ae_at_4", 32'(almost_empty), 32'd1);
    step(1'b1, 8'h54, 1'b0, 1'b0);
    chk("ae_at_5", 32'(almost_empty), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("ae_after_pop", 32'(almost_empty), 32'd1);
    chk("ae_head", 32'(data_out), 32'h51);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
